// File: rtl/fifo_pkg.sv
// Shared definitions for the programmable synchronous FIFO family.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } status_t;

  // Width able to hold every occupancy value from 0 up to and including depth.
  function automatic int clog2_depth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Handshake, status and threshold bundle between a client and sync_fifo_prog.
interface sync_fifo_prog_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
);
  localparam int CNT_W = clog2_depth(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      af_thresh;
  logic [CNT_W-1:0]      ae_thresh;
  logic [CNT_W-1:0]      level;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  ovf_sticky;
  logic                  udf_sticky;
  logic                  clr_sticky;

  modport master (
    output wr_en, data_in, rd_en, af_thresh, ae_thresh, clr_sticky,
    input  data_out, valid, full, empty, almost_full, almost_empty, level,
           wr_ack, overflow, underflow, ovf_sticky, udf_sticky
  );

  modport slave (
    input  wr_en, data_in, rd_en, af_thresh, ae_thresh, clr_sticky,
    output data_out, valid, full, empty, almost_full, almost_empty, level,
           wr_ack, overflow, underflow, ovf_sticky, udf_sticky
  );

endinterface

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer; wraps explicitly so non-power-of-two depths work.
module fifo_wrap_ptr #(
  parameter int DEPTH = 8,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with arbitrary depth, std/FWFT read mode, programmable
// almost-full/empty thresholds, fill level, status pulses and sticky errors.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int FWFT       = 0
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_prog_if.slave bus
);

  localparam int CNT_W = clog2_depth(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      level_q;
  status_t               stat;
  logic                  rd_acc;
  logic                  wr_acc;

  // Status comes only from the registered level, never from wr_en/rd_en.
  always_comb begin
    stat.full         = (level_q == CNT_W'(DEPTH));
    stat.empty        = (level_q == '0);
    stat.almost_full  = (level_q >= bus.af_thresh);
    stat.almost_empty = (level_q <= bus.ae_thresh);
  end

  assign rd_acc = bus.rd_en && !stat.empty;
  assign wr_acc = bus.wr_en && (!stat.full || rd_acc);

  assign bus.full         = stat.full;
  assign bus.empty        = stat.empty;
  assign bus.almost_full  = stat.almost_full;
  assign bus.almost_empty = stat.almost_empty;
  assign bus.level        = level_q;

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_acc),
    .ptr (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_acc),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
    end else if (wr_acc && !rd_acc) begin
      level_q <= level_q + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      level_q <= level_q - CNT_W'(1);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wr_ack     <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.underflow  <= 1'b0;
      bus.ovf_sticky <= 1'b0;
      bus.udf_sticky <= 1'b0;
    end else begin
      bus.wr_ack    <= wr_acc;
      bus.overflow  <= bus.wr_en && !wr_acc;
      bus.underflow <= bus.rd_en && !rd_acc;
      if (bus.wr_en && !wr_acc) begin
        bus.ovf_sticky <= 1'b1;
      end else if (bus.clr_sticky) begin
        bus.ovf_sticky <= 1'b0;
      end
      if (bus.rd_en && !rd_acc) begin
        bus.udf_sticky <= 1'b1;
      end else if (bus.clr_sticky) begin
        bus.udf_sticky <= 1'b0;
      end
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign bus.data_out = mem[rd_ptr];
      assign bus.valid    = !stat.empty;
    end else begin : g_std
      // data_out holds the last word read; valid marks a fresh one.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          bus.data_out <= '0;
          bus.valid    <= 1'b0;
        end else begin
          bus.valid <= rd_acc;
          if (rd_acc) begin
            bus.data_out <= mem[rd_ptr];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Randomised self-checking bench for sync_fifo_prog in std and FWFT modes.
module tb_sync_fifo_prog;

  localparam int DW    = 16;
  localparam int DEPTH = 6;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_sticky = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [CW-1:0] af_thresh = 3'd4;
  logic [CW-1:0] ae_thresh = 3'd1;

  int total = 0;
  int bad   = 0;

  sync_fifo_prog_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) s_if ();
  sync_fifo_prog_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) f_if ();

  assign s_if.wr_en      = wr_en;
  assign s_if.rd_en      = rd_en;
  assign s_if.data_in    = data_in;
  assign s_if.af_thresh  = af_thresh;
  assign s_if.ae_thresh  = ae_thresh;
  assign s_if.clr_sticky = clr_sticky;
  assign f_if.wr_en      = wr_en;
  assign f_if.rd_en      = rd_en;
  assign f_if.data_in    = data_in;
  assign f_if.af_thresh  = af_thresh;
  assign f_if.ae_thresh  = ae_thresh;
  assign f_if.clr_sticky = clr_sticky;

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk (clk),
    .rst (rst),
    .bus (s_if.slave)
  );

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (f_if.slave)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: a queue of stored words plus the pulse/sticky state.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_valid, m_wr_ack, m_ovf, m_udf, m_ovs, m_uds;
  logic          m_ra, m_wa;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_dout = '0; m_valid = 0; m_wr_ack = 0; m_ovf = 0; m_udf = 0; m_ovs = 0; m_uds = 0;
    end else begin
      m_ra = rd_en && (q.size() > 0);
      m_wa = wr_en && ((q.size() < DEPTH) || m_ra);
      m_valid = m_ra;
      if (m_ra) m_dout = q.pop_front();
      if (m_wa) q.push_back(data_in);
      m_wr_ack = m_wa;
      m_ovf = wr_en && !m_wa;
      m_udf = rd_en && !m_ra;
      if (m_ovf) m_ovs = 1'b1; else if (clr_sticky) m_ovs = 1'b0;
      if (m_udf) m_uds = 1'b1; else if (clr_sticky) m_uds = 1'b0;
    end
  end

  always @(negedge clk) begin
    int lvl;
    lvl = q.size();
    check("level_std",  32'(s_if.level), 32'(lvl));
    check("level_fwft", 32'(f_if.level), 32'(lvl));
    check("full",         32'(s_if.full),         32'(lvl == DEPTH));
    check("empty",        32'(s_if.empty),        32'(lvl == 0));
    check("almost_full",  32'(s_if.almost_full),  32'(lvl >= int'(af_thresh)));
    check("almost_empty", 32'(s_if.almost_empty), 32'(lvl <= int'(ae_thresh)));
    check("fwft_full",    32'(f_if.full),         32'(lvl == DEPTH));
    check("fwft_af",      32'(f_if.almost_full),  32'(lvl >= int'(af_thresh)));
    check("wr_ack",     32'(s_if.wr_ack),     32'(m_wr_ack));
    check("overflow",   32'(s_if.overflow),   32'(m_ovf));
    check("underflow",  32'(s_if.underflow),  32'(m_udf));
    check("ovf_sticky", 32'(s_if.ovf_sticky), 32'(m_ovs));
    check("udf_sticky", 32'(s_if.udf_sticky), 32'(m_uds));
    check("fwft_ovf_sticky", 32'(f_if.ovf_sticky), 32'(m_ovs));
    check("fwft_udf_sticky", 32'(f_if.udf_sticky), 32'(m_uds));
    check("std_valid", 32'(s_if.valid),    32'(m_valid));
    check("std_data",  32'(s_if.data_out), 32'(m_dout));
    check("fwft_valid", 32'(f_if.valid), 32'(lvl > 0));
    if (lvl > 0) check("fwft_data", 32'(f_if.data_out), 32'(q[0]));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("pin_rst_level", 32'(s_if.level), 32'd0);
    check("pin_rst_empty", 32'(s_if.empty), 32'd1);
    check("pin_rst_ae",    32'(s_if.almost_empty), 32'd1);

    // FWFT: word written into an empty FIFO shows up with no read
    wr_en = 1; data_in = 16'h00A5; cyc(); wr_en = 0;
    @(negedge clk);
    check("pin_fwft_valid", 32'(f_if.valid), 32'd1);
    check("pin_fwft_data",  32'(f_if.data_out), 32'h00A5);
    #1 rd_en = 1; cyc(); rd_en = 0;

    for (int i = 1; i <= 6; i++) begin
      wr_en = 1; data_in = 16'(i * 16'h11); cyc();
    end
    wr_en = 0;
    @(negedge clk);
    check("pin_fill_level", 32'(s_if.level), 32'd6);
    check("pin_fill_full",  32'(s_if.full),  32'd1);

    #1 wr_en = 1; data_in = 16'h0077; cyc(); wr_en = 0;
    @(negedge clk);
    check("pin_overflow",   32'(s_if.overflow),   32'd1);
    check("pin_ovf_sticky", 32'(s_if.ovf_sticky), 32'd1);

    // full with simultaneous read and write
    #1 wr_en = 1; rd_en = 1; data_in = 16'h0099; cyc(); wr_en = 0; rd_en = 0;
    @(negedge clk);
    check("pin_fullrw_level", 32'(s_if.level),    32'd6);
    check("pin_fullrw_ovf",   32'(s_if.overflow), 32'd0);
    check("pin_fullrw_data",  32'(s_if.data_out), 32'h0011);

    #1 rd_en = 1;
    repeat (7) cyc();
    rd_en = 0;
    @(negedge clk);
    check("pin_udf",        32'(s_if.underflow),  32'd1);
    check("pin_udf_sticky", 32'(s_if.udf_sticky), 32'd1);
    check("pin_udf_hold",   32'(s_if.data_out),   32'h0099);

    #1 wr_en = 1; rd_en = 1; data_in = 16'h0055; cyc(); wr_en = 0; rd_en = 0;
    @(negedge clk);
    check("pin_emptyrw_level", 32'(s_if.level),     32'd1);
    check("pin_emptyrw_udf",   32'(s_if.underflow), 32'd1);

    #1 clr_sticky = 1; cyc(); clr_sticky = 0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; data_in = 16'($urandom_range(0, 65535)); cyc();
    end
    clr_sticky = 1; cyc(); wr_en = 0; clr_sticky = 0;
    @(negedge clk);
    check("pin_set_wins", 32'(s_if.ovf_sticky), 32'd1);

    // drain to 3, then interleaved pairs to walk pointers past the wrap
    #1 rd_en = 1; repeat (3) cyc(); rd_en = 0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1; rd_en = 1; data_in = 16'(16'h0100 + i); cyc();
    end
    wr_en = 0; rd_en = 0;
    @(negedge clk);
    check("pin_wrap_level", 32'(s_if.level), 32'd3);

    // asynchronous reset mid-fill takes effect without a clock edge
    @(posedge clk); #2 rst = 1; #1;
    check("pin_arst_empty", 32'(f_if.empty), 32'd1);
    check("pin_arst_level", 32'(f_if.level), 32'd0);
    check("pin_arst_valid", 32'(f_if.valid), 32'd0);
    @(posedge clk); #3 rst = 0;

    for (int n = 0; n < 3000; n++) begin
      wr_en      = ($urandom_range(0, 99) < 55);
      rd_en      = ($urandom_range(0, 99) < 50);
      data_in    = 16'($urandom_range(0, 65535));
      clr_sticky = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) af_thresh = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) ae_thresh = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1; #4 rst = 0;
      end
      cyc();
    end
    wr_en = 0; rd_en = 0; clr_sticky = 0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised successor to the team's single-clock FIFO. It supports any depth (not only powers of two) and arbitrary data width, with a compile-time choice between registered-read and first-word-fall-through (FWFT) mode. It adds run-time programmable almost-full/almost-empty thresholds, a fill-level output, registered status pulses and sticky error flags. It sits between producer and consumer blocks in the same clock domain as the standard buffering primitive.

Parameters:
DATA_WIDTH, 16, width of data_in/data_out in bits (>=1)
DEPTH, 8, number of entries (>=2, any integer)
FWFT, 0, 0 = registered read with 1-cycle latency; 1 = head word presented combinationally on data_out
CNT_W, $clog2(DEPTH+1), derived localparam, width of level and thresholds (not overridable)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
wr_en  in  1  write request
data_in  in  DATA_WIDTH  write data
rd_en  in  1  read request (pop in FWFT mode)
data_out  out  DATA_WIDTH  read data
valid  out  1  data_out holds a freshly read word (std) / head word valid (FWFT)
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= af_thresh
almost_empty  out  1  level <= ae_thresh
af_thresh  in  CNT_W  almost-full threshold, sampled live
ae_thresh  in  CNT_W  almost-empty threshold, sampled live
level  out  CNT_W  current occupancy
wr_ack  out  1  registered pulse: write accepted last cycle
overflow  out  1  registered pulse: write rejected last cycle
underflow  out  1  registered pulse: read rejected last cycle
ovf_sticky  out  1  latched overflow
udf_sticky  out  1  latched underflow
clr_sticky  in  1  clears both sticky flags

Behaviour:
- Reset (async, rst high): wr_ptr=rd_ptr=0, level=0, data_out=0, valid=0, wr_ack=overflow=underflow=0, stickies=0. Thus empty=1, full=0, almost_empty=(0<=ae_thresh)=1. Memory contents are not reset.
- Reset mid-operation discards all contents immediately. The first edge after rst falls behaves as empty.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_acc). When full, a simultaneous read and write are both accepted and level is unchanged.
- When empty, a simultaneous read and write accepts only the write; the read is rejected and flagged as underflow.
- Level update: +1 if wr_acc && !rd_acc; -1 if rd_acc && !wr_acc; otherwise unchanged. Level never exceeds DEPTH and never goes below 0.
- Pointers wrap explicitly from DEPTH-1 to 0, which is required for non-power-of-two depths. The write goes to mem[wr_ptr].
- Standard mode (FWFT=0): on rd_acc, data_out <= mem[rd_ptr] and valid <= 1 on the next edge. Otherwise valid <= 0 and data_out holds its last value. Latency is 1 cycle.
- FWFT mode (FWFT=1): data_out = mem[rd_ptr] combinationally; valid = !empty; rd_en pops the head. A word written into an empty FIFO appears on data_out one cycle after the write edge.
- wr_ack <= wr_acc; overflow <= wr_en && !wr_acc; underflow <= rd_en && !rd_acc. All three are single-cycle pulses.
- ovf_sticky sets when overflow is set; udf_sticky likewise. clr_sticky clears both. If set and clear occur in the same cycle, set wins.
- Thresholds are compared combinationally every cycle.
  - af_thresh=0 forces almost_full=1.
  - ae_thresh>=DEPTH forces almost_empty=1.
  - Values above DEPTH are legal and are not clamped.
- full, empty, almost_full, almost_empty and level derive only from registered level; none has a combinational path from wr_en or rd_en.

Decomposition:
- Package fifo_pkg holds:
  - the function clog2_depth;
  - the mode constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1;
  - the typedef struct status_t {full, empty, almost_full, almost_empty}, used by wrappers.
- One sub-module, fifo_wrap_ptr: a parametrised modulo-DEPTH pointer with an increment enable and async reset. It is instantiated twice, for wr_ptr and rd_ptr.

Test Plan:
- DEPTH=6, FWFT=0: write 0x11..0x66 (6 writes) -> full=1 after the 6th edge, level=6, wr_ack pulses 6 times. A 7th write gives overflow=1 for one cycle, ovf_sticky=1, and memory is unchanged.
- Same fill, then 6 reads -> data_out 0x11..0x66 each one cycle after rd_en, with valid high for each. A 7th read gives underflow pulse, udf_sticky=1, and data_out holds 0x66.
- Wrap on non-power-of-two depth: 10 interleaved write/read pairs at level 3 -> pointers wrap 5->0, data order preserved, level stays 3.
- Full plus simultaneous read and write: both accepted, level stays 6, no overflow, and the new word is read out 6 reads later. Empty plus simultaneous read and write: level becomes 1 and an underflow pulse is raised.
- Thresholds af_thresh=4, ae_thresh=1: almost_full rises on the edge where level reaches 4. almost_empty is high at level 0 and 1 and low at level 2. Raising clr_sticky in the same cycle as a new overflow leaves ovf_sticky=1.
- FWFT=1: write 0xA5 into an empty FIFO -> next cycle valid=1 and data_out=0xA5 with no rd_en. Assert rst mid-fill at level 3 -> immediately empty=1, valid=0, level=0.
